// File: rtl/sar_ctrl.sv
// ---------------------------------------------------------------------------
// sar_ctrl -- successive-approximation ADC controller
//
// Runs one conversion per accepted start request. The analog input is tracked
// for SAMPLE_CYCLES clocks, then one binary-search decision is made per bit,
// MSB first, using the comparator answer for the current trial code. The
// finished code is presented on a valid/ready port. A result that completes
// while the previous one is still unconsumed overwrites it and raises a
// one-cycle overrun pulse.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   start       conversion request, only looked at while idle
//   busy        high while sampling or converting
//   sample      track-switch enable, high only while sampling
//   dac_code    trial code for the voltage DAC
//   comp_in     comparator decision, 1 when vin >= vdac(dac_code); must be
//               valid combinationally in the same cycle as dac_code
//   dout        last completed conversion result
//   dout_valid  dout holds a result that has not been consumed yet
//   dout_ready  consumer takes dout when dout_valid && dout_ready
//   overrun     one-cycle pulse: an unconsumed result was overwritten
// ---------------------------------------------------------------------------
module sar_ctrl #(
  parameter int DAC_BITS      = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                sample,
  output logic [DAC_BITS-1:0] dac_code,
  input  logic                comp_in,
  output logic [DAC_BITS-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overrun
);

  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int IDX_W = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_MSB  = IDX_W'(DAC_BITS - 1);
  localparam logic [DAC_BITS-1:0] MSB_ONLY = DAC_BITS'(1) << (DAC_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT
  } state_t;

  state_t              state_reg,      state_next;
  logic [CNT_W-1:0]    cnt_reg,        cnt_next;
  logic [IDX_W-1:0]    idx_reg,        idx_next;
  logic [DAC_BITS-1:0] code_reg,       code_next;
  logic [DAC_BITS-1:0] dout_reg,       dout_next;
  logic                dout_valid_reg, dout_valid_next;
  logic                overrun_reg,    overrun_next;

  // Trial code with the bit under test replaced by the comparator answer.
  logic [DAC_BITS-1:0] decided;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= IDX_MSB;
      code_reg       <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      code_reg       <= code_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    code_next       = code_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    overrun_next    = 1'b0;

    decided          = code_reg;
    decided[idx_reg] = comp_in;

    // Consumer handshake; a completion below takes priority and keeps the
    // valid flag set, which covers the accept-and-reload case.
    if (dout_valid_reg && dout_ready) begin
      dout_valid_next = 1'b0;
    end

    unique case (state_reg)
      ST_IDLE: begin
        code_next = '0;
        if (start) begin
          state_next = ST_SAMPLE;
          cnt_next   = '0;
        end
      end

      ST_SAMPLE: begin
        code_next = '0;
        cnt_next  = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_CONVERT;
          cnt_next   = '0;
          code_next  = MSB_ONLY;
          idx_next   = IDX_MSB;
        end
      end

      ST_CONVERT: begin
        if (idx_reg != '0) begin
          // Keep the decision, then put the next lower bit on trial.
          code_next                       = decided;
          code_next[idx_reg - IDX_W'(1)] = 1'b1;
          idx_next                        = idx_reg - IDX_W'(1);
        end else begin
          dout_next       = decided;
          dout_valid_next = 1'b1;
          // Overwriting a result nobody has taken is an overrun; if it is
          // being taken on this very edge it is a clean hand-over.
          overrun_next    = dout_valid_reg && !dout_ready;
          state_next      = ST_IDLE;
          code_next       = '0;
          idx_next        = IDX_MSB;
        end
      end

      default: begin
        state_next = ST_IDLE;
        code_next  = '0;
      end
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign sample     = (state_reg == ST_SAMPLE);
  assign dac_code   = code_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_ctrl -- self-checking bench for sar_ctrl (DAC_BITS=8, SAMPLE_CYCLES=2)
//
// The analog side is an ideal comparator over a 0..0.9 V DAC, with voltages
// kept as integer microvolts so that the code boundaries are exact. The
// reference model tracks only the age of the running conversion and the
// expected result floor(vin/LSB); every visible output is derived from those.
// ---------------------------------------------------------------------------
module tb_sar_ctrl;

  localparam int     DB    = 8;
  localparam int     SC    = 2;
  localparam longint FS_UV = 900000;
  localparam longint STEPS = longint'(1) << DB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          sample;
  logic [DB-1:0] dac_code;
  logic          comp_in;
  logic [DB-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          overrun;

  longint vin_uv = 0;

  int checks = 0;
  int errors = 0;

  sar_ctrl #(
    .DAC_BITS      (DB),
    .SAMPLE_CYCLES (SC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .sample     (sample),
    .dac_code   (dac_code),
    .comp_in    (comp_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Ideal comparator: vin >= code * FS / 2^DB, cross-multiplied.
  assign comp_in = (vin_uv * STEPS >= longint'(dac_code) * FS_UV);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ideal_code(input longint v);
    longint c;
    c = (v * STEPS) / FS_UV;
    if (c > STEPS - 1) c = STEPS - 1;
    return int'(c);
  endfunction

  // -------------------------------------------------------------------------
  // Reference model: age = cycles since the start was captured (0 = idle).
  // Ages 1..SC are the track phase, SC+1..SC+DB test bits DB-1..0, and the
  // edge leaving age SC+DB publishes the result.
  // -------------------------------------------------------------------------
  int m_age   = 0;
  int m_res   = 0;
  int m_dout  = 0;
  bit m_valid = 0;
  bit m_ovr   = 0;
  bit m_live  = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age = 0; m_dout = 0; m_valid = 0; m_ovr = 0; m_live = 1;
    end else if (m_live) begin
      if (m_age == SC + DB) begin
        m_ovr   = m_valid && !dout_ready;
        m_dout  = m_res;
        m_valid = 1;
        m_age   = 0;
      end else begin
        m_ovr = 0;
        if (m_valid && dout_ready) m_valid = 0;
        if (m_age == 0) begin
          if (start) begin
            m_age = 1;
            m_res = ideal_code(vin_uv);
          end
        end else begin
          m_age++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      int j;
      int exp_dac;
      exp_dac = 0;
      if (m_age > SC) begin
        j = SC + DB - m_age;
        exp_dac = ((m_res >> (j + 1)) << (j + 1)) | (1 << j);
      end
      chk("busy",       32'(busy),       32'(m_age != 0));
      chk("sample",     32'(sample),     32'(m_age >= 1 && m_age <= SC));
      chk("dac_code",   32'(dac_code),   32'(exp_dac));
      chk("dout",       32'(dout),       32'(m_dout));
      chk("dout_valid", 32'(dout_valid), 32'(m_valid));
      chk("overrun",    32'(overrun),    32'(m_ovr));
    end
  end

  // Observation of DUT activity for the directed scenarios.
  int       cyc = 0;
  logic [7:0] seq[$];
  int       valid_rise[$];
  int       busy_cnt = 0;
  int       busy_rises = 0;
  int       ovr_cnt = 0;
  bit       prev_busy = 0;
  bit       prev_valid = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy === 1'b1 && sample === 1'b0) seq.push_back(dac_code);
    if (busy === 1'b1) busy_cnt++;
    if (busy === 1'b1 && !prev_busy) busy_rises++;
    if (overrun === 1'b1) ovr_cnt++;
    if (dout_valid === 1'b1 && !prev_valid) valid_rise.push_back(cyc);
    prev_busy  = (busy === 1'b1);
    prev_valid = (dout_valid === 1'b1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic conv(input longint v);
    vin_uv = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_idle(40);
  endtask

  logic [7:0] seq_mid[8];
  logic [7:0] seq_full[8];

  initial begin
    seq_mid  = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81};
    seq_full = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    // Reset
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_dout",  32'(dout), 32'(0));
    chk("rst_valid", 32'(dout_valid), 32'(0));
    chk("rst_busy",  32'(busy), 32'(0));

    // Mid-scale: trial sequence, latency and busy length
    seq.delete();
    busy_cnt = 0;
    conv(450000);
    chk("mid_seq_len", 32'(seq.size()), 32'(8));
    for (int k = 0; k < 8 && k < seq.size(); k++) chk("mid_seq", 32'(seq[k]), 32'(seq_mid[k]));
    chk("mid_busy_cycles", 32'(busy_cnt), 32'(10));
    chk("mid_dout",  32'(dout), 32'h80);
    chk("mid_valid", 32'(dout_valid), 32'(1));

    // Zero and full scale with the consumer always ready
    dout_ready = 1'b1;
    tick(); tick();
    conv(0);
    chk("zero_dout", 32'(dout), 32'h00);
    tick(); tick();
    seq.delete();
    conv(900000);
    chk("full_dout", 32'(dout), 32'hFF);
    for (int k = 0; k < 8 && k < seq.size(); k++) chk("full_seq", 32'(seq[k]), 32'(seq_full[k]));
    tick(); tick();

    // Continuous start: one result every SC+DB+1 cycles
    vin_uv = 300000;
    valid_rise.delete();
    start = 1'b1;
    repeat (35) tick();
    start = 1'b0;
    wait_idle(40);
    tick();
    chk("cont_count", 32'(valid_rise.size()), 32'(4));
    if (valid_rise.size() >= 3) begin
      chk("cont_period1", 32'(valid_rise[1] - valid_rise[0]), 32'(11));
      chk("cont_period2", 32'(valid_rise[2] - valid_rise[1]), 32'(11));
    end
    chk("cont_dout", 32'(dout), 32'h55);
    tick();

    // Stalled consumer, back-to-back conversions: one overrun
    dout_ready = 1'b0;
    tick(); tick();
    ovr_cnt = 0;
    conv(450000);
    conv(0);
    tick();
    chk("ovr_count", 32'(ovr_cnt), 32'(1));
    chk("ovr_dout",  32'(dout), 32'h00);
    chk("ovr_valid", 32'(dout_valid), 32'(1));

    // Reset after three decided bits
    dout_ready = 1'b1;
    tick(); tick();
    vin_uv = 900000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SC + 3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy",  32'(busy), 32'(0));
    chk("abort_dac",   32'(dac_code), 32'(0));
    chk("abort_dout",  32'(dout), 32'(0));
    chk("abort_valid", 32'(dout_valid), 32'(0));
    tick();
    conv(300000);
    chk("after_abort_dout", 32'(dout), 32'h55);
    tick(); tick();

    // start during SAMPLE and CONVERT is ignored
    busy_rises = 0;
    valid_rise.delete();
    vin_uv = 450000;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle(40);
    tick(); tick(); tick();
    chk("ignore_busy_rises", 32'(busy_rises), 32'(1));
    chk("ignore_results",    32'(valid_rise.size()), 32'(1));

    // Randomized traffic; vin only changes while idle
    for (int n = 0; n < 3000; n++) begin
      if (m_age == 0) vin_uv = longint'($urandom_range(0, 1000000));
      start      = ($urandom_range(0, 3) == 0);
      dout_ready = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
